// File: rtl/snes_video_pkg.sv
// Shared video types, the 720p window defaults and the BGR555 -> RGB888 expansion.
package snes_video_pkg;

   typedef logic [14:0] rgb555_t;
   typedef logic [23:0] rgb888_t;

   typedef enum logic [1:0] {IDLE, ARMED, HOLD, RUN} sync_state_e;

   localparam int HD_H_ACTIVE = 1280;
   localparam int HD_V_ACTIVE = 720;
   localparam int DEF_SCALE   = 3;
   localparam int DEF_H_OFF   = (HD_H_ACTIVE - 256 * DEF_SCALE) / 2;
   localparam int DEF_V_OFF   = (HD_V_ACTIVE - 224 * DEF_SCALE) / 2;

   function automatic rgb888_t expand555(input rgb555_t d);
      return {d[4:0], 3'b000, d[9:5], 3'b000, d[14:10], 3'b000};
   endfunction

endpackage

// File: rtl/snes_linebuf_scaler_if.sv
// Pixel-write, display-raster and status bundle between the SNES/HDMI side (master) and the scaler (slave).
interface snes_linebuf_scaler_if;
   import snes_video_pkg::*;

   logic        pix_we;
   logic [7:0]  pix_x;
   logic [7:0]  pix_y;
   rgb555_t     pix_rgb;
   logic        line_done;
   logic        frame_start;
   logic [10:0] disp_cx;
   logic [9:0]  disp_cy;
   rgb888_t     rgb_out;
   logic        rgb_active;
   logic        pause_src;
   logic [15:0] underrun_cnt;
   logic [7:0]  sync_timeouts;

   modport master (
      output pix_we, pix_x, pix_y, pix_rgb, line_done, frame_start, disp_cx, disp_cy,
      input  rgb_out, rgb_active, pause_src, underrun_cnt, sync_timeouts
   );

   modport slave (
      input  pix_we, pix_x, pix_y, pix_rgb, line_done, frame_start, disp_cx, disp_cy,
      output rgb_out, rgb_active, pause_src, underrun_cnt, sync_timeouts
   );

endinterface

// File: rtl/linebuf_ram.sv
// Simple dual-port line RAM, one write port and one registered read port; read latency 1 cycle.
// No backpressure; contents are deliberately not reset so it maps onto block RAM.
module linebuf_ram #(
   parameter int AW = 12,
   parameter int DW = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdat,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdat
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdat_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdat;
      rdat_q <= mem[raddr];
   end

   assign rdat = rdat_q;

endmodule

// File: rtl/snes_linebuf_scaler.sv
// SNES line-buffer upscaler with underrun flagging, overrun throttle and frame-sync pause; SNES_SCANLINE_EN dims the last sub-row of each source line.
// Latency 2 cycles disp_cx/disp_cy -> rgb_out; display side never stalls, pause_src is the only backpressure onto the SNES.
module snes_linebuf_scaler
   import snes_video_pkg::*;
#(
   parameter int      SRC_W        = 256,
   parameter int      SRC_H        = 224,
   parameter int      SCALE        = DEF_SCALE,
   parameter int      LINE_BITS    = 4,
   parameter int      H_OFF        = DEF_H_OFF,
   parameter int      V_OFF        = DEF_V_OFF,
   parameter int      SYNC_LINES   = 2,
   parameter int      TIMEOUT      = 2000000,
   parameter rgb888_t BORDER_RGB   = 24'h303030,
   parameter rgb888_t UNDERRUN_RGB = 24'hFF00FF
) (
   input logic                  clk,
   input logic                  resetn,
   snes_linebuf_scaler_if.slave bus
);

   localparam int XW     = $clog2(SRC_W);
   localparam int AW     = LINE_BITS + XW;
   localparam int NLINES = 1 << LINE_BITS;
   localparam int X_END  = H_OFF + SRC_W * SCALE;
   localparam int Y_END  = V_OFF + SRC_H * SCALE;
   localparam int TW     = $clog2(TIMEOUT + 1);

   logic          wr_en;
   logic [AW-1:0] wr_addr, rd_addr;
   rgb555_t       rd_dat;
   logic [8:0]    wr_count_q, wr_count_d;

   logic [2:0]    xsub_q, xsub_d, xsub_c, ysub_q, ysub_d;
   logic [XW-1:0] sx_q, sx_d, sx_c;
   logic [7:0]    sy_q, sy_d;
   logic          cx0_q, cx0_d, row_start;
   logic          in_x, in_y, act0, und0, dim0;
   logic          act1_q, und1_q, dim1_q;
   logic          und_row_q, und_row_d;
   logic [15:0]   und_cnt_q, und_cnt_d;
   rgb888_t       rgb_q, rgb_d;
   logic          rgb_act_q;

   sync_state_e   state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    tout_q, tout_d;
   logic          thr_q, thr_d, pause_q, pause_d;
   logic [8:0]    gap;

   assign wr_en   = bus.pix_we && ({1'b0, bus.pix_y} < 9'(SRC_H)) && ({1'b0, bus.pix_x} < 9'(SRC_W));
   assign wr_addr = {bus.pix_y[LINE_BITS-1:0], bus.pix_x[XW-1:0]};
   assign rd_addr = {sy_q[LINE_BITS-1:0], sx_c};

   linebuf_ram #(.AW(AW), .DW(15)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdat  (bus.pix_rgb),
      .raddr (rd_addr),
      .rdat  (rd_dat)
   );

   always_comb begin
      wr_count_d = wr_count_q;
      if (bus.frame_start)
         wr_count_d = '0;
      else if (bus.line_done && (wr_count_q < 9'(SRC_H)))
         wr_count_d = wr_count_q + 9'd1;
   end

   assign in_x      = (bus.disp_cx >= 11'(H_OFF)) && (bus.disp_cx < 11'(X_END));
   assign in_y      = (bus.disp_cy >= 10'(V_OFF)) && (bus.disp_cy < 10'(Y_END));
   assign act0      = in_x && in_y;
   assign cx0_d     = (bus.disp_cx == '0);
   // Rows advance only on the first cycle of cx==0, so a parked raster does not run sy away.
   assign row_start = cx0_d && !cx0_q;
   assign und0      = act0 && ({1'b0, sy_q} >= wr_count_q);

   always_comb begin
      xsub_c = xsub_q;
      sx_c   = sx_q;
      if (bus.disp_cx == 11'(H_OFF)) begin
         xsub_c = '0;
         sx_c   = '0;
      end
      xsub_d = (xsub_c == 3'(SCALE - 1)) ? 3'd0 : xsub_c + 3'd1;
      sx_d   = (xsub_c == 3'(SCALE - 1)) ? sx_c + 1'b1 : sx_c;

      ysub_d = ysub_q;
      sy_d   = sy_q;
      if (cx0_d && (bus.disp_cy == 10'(V_OFF))) begin
         ysub_d = '0;
         sy_d   = '0;
      end else if (row_start && in_y) begin
         if (ysub_q == 3'(SCALE - 1)) begin
            ysub_d = '0;
            sy_d   = sy_q + 8'd1;
         end else begin
            ysub_d = ysub_q + 3'd1;
         end
      end
   end

`ifdef SNES_SCANLINE_EN
   assign dim0 = act0 && (ysub_q == 3'(SCALE - 1));
`else
   assign dim0 = 1'b0;
`endif

   always_comb begin
      und_row_d = cx0_d ? 1'b0 : (und_row_q | und0);
      und_cnt_d = und_cnt_q;
      if (und0 && !und_row_q && (und_cnt_q != 16'hFFFF))
         und_cnt_d = und_cnt_q + 16'd1;
   end

   always_comb begin
      rgb_d = BORDER_RGB;
      if (act1_q) begin
         rgb_d = und1_q ? UNDERRUN_RGB : expand555(rd_dat);
`ifdef SNES_SCANLINE_EN
         if (dim1_q)
            rgb_d = {1'b0, rgb_d[23:17], 1'b0, rgb_d[15:9], 1'b0, rgb_d[7:1]};
`endif
      end
   end

   assign gap = (wr_count_q >= {1'b0, sy_q}) ? (wr_count_q - {1'b0, sy_q}) : 9'd0;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      tout_d  = tout_q;
      thr_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.frame_start) state_d = ARMED;
         ARMED: begin
            if (!bus.frame_start && (wr_count_q == 9'(SYNC_LINES))) begin
               state_d = HOLD;
               tmo_d   = '0;
            end
         end
         HOLD: begin
            if (bus.frame_start) begin
               state_d = ARMED;
            end else if ((bus.disp_cy == 10'(V_OFF)) && (bus.disp_cx == 11'(H_OFF))) begin
               state_d = RUN;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = RUN;
               if (tout_q != 8'hFF) tout_d = tout_q + 8'd1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RUN: begin
            if (bus.frame_start) begin
               state_d = ARMED;
            end else if (gap >= 9'(NLINES - 1)) begin
               thr_d = 1'b1;
            end else if (gap > 9'(NLINES - 3)) begin
               thr_d = thr_q;
            end
         end
         default: state_d = IDLE;
      endcase
      pause_d = (state_d == HOLD) || ((state_d == RUN) && thr_d);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_count_q <= '0;
         xsub_q     <= '0;
         sx_q       <= '0;
         ysub_q     <= '0;
         sy_q       <= '0;
         cx0_q      <= 1'b1;
         act1_q     <= 1'b0;
         und1_q     <= 1'b0;
         dim1_q     <= 1'b0;
         und_row_q  <= 1'b0;
         und_cnt_q  <= '0;
         rgb_q      <= BORDER_RGB;
         rgb_act_q  <= 1'b0;
         state_q    <= IDLE;
         tmo_q      <= '0;
         tout_q     <= '0;
         thr_q      <= 1'b0;
         pause_q    <= 1'b0;
      end else begin
         wr_count_q <= wr_count_d;
         xsub_q     <= xsub_d;
         sx_q       <= sx_d;
         ysub_q     <= ysub_d;
         sy_q       <= sy_d;
         cx0_q      <= cx0_d;
         act1_q     <= act0;
         und1_q     <= und0;
         dim1_q     <= dim0;
         und_row_q  <= und_row_d;
         und_cnt_q  <= und_cnt_d;
         rgb_q      <= rgb_d;
         rgb_act_q  <= act1_q;
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         tout_q     <= tout_d;
         thr_q      <= thr_d;
         pause_q    <= pause_d;
      end
   end

   assign bus.rgb_out       = rgb_q;
   assign bus.rgb_active    = rgb_act_q;
   assign bus.pause_src     = pause_q;
   assign bus.underrun_cnt  = und_cnt_q;
   assign bus.sync_timeouts = tout_q;

endmodule

// File: tb/tb_snes_linebuf_scaler.sv
// Directed bench for snes_linebuf_scaler with SCALE=3, LINE_BITS=4, TIMEOUT=100.
module tb_snes_linebuf_scaler;
   import snes_video_pkg::*;

   logic clk = 1'b0;
   logic resetn;

   snes_linebuf_scaler_if bus();

   snes_linebuf_scaler #(.TIMEOUT(100)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

`ifdef SNES_SCANLINE_EN
   localparam logic [23:0] R26 = 24'h7C0000;
   localparam logic [23:0] W26 = 24'h7C7C7C;
   localparam logic [23:0] G26 = 24'h007C00;
`else
   localparam logic [23:0] R26 = 24'hF80000;
   localparam logic [23:0] W26 = 24'hF8F8F8;
   localparam logic [23:0] G26 = 24'h00F800;
`endif

   typedef struct {
      int          cy;
      int          cx;
      logic [23:0] rgb;
      logic        act;
   } vec_t;

   vec_t        vt [14];
   logic [23:0] cap_rgb [0:1102];
   logic        cap_act [0:1102];
   logic        pz      [0:1102];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
   endtask

   task automatic pulse_ld();
      @(negedge clk) bus.line_done = 1'b1;
      @(negedge clk) bus.line_done = 1'b0;
   endtask

   task automatic pulse_fs();
      @(negedge clk) bus.frame_start = 1'b1;
      @(negedge clk) bus.frame_start = 1'b0;
   endtask

   task automatic wr_pix(input int y, input int x, input logic [14:0] c);
      @(negedge clk);
      bus.pix_we  = 1'b1;
      bus.pix_y   = 8'(y);
      bus.pix_x   = 8'(x);
      bus.pix_rgb = c;
   endtask

   task automatic next_row(input int cy);
      @(negedge clk);
      bus.disp_cy = 10'(cy);
      bus.disp_cx = 11'd0;
      @(negedge clk) bus.disp_cx = 11'd1;
   endtask

   // cap_* is indexed by the cx that produced the sample; pz by the cycle the cx was driven.
   task automatic sweep_row(input int cy, input int c0);
      for (int i = c0; i <= 1102; i++) begin
         @(negedge clk);
         if (i - 2 >= c0) begin
            cap_rgb[i-2] = bus.rgb_out;
            cap_act[i-2] = bus.rgb_active;
         end
         pz[i]       = bus.pause_src;
         bus.disp_cy = 10'(cy);
         bus.disp_cx = 11'((i > 1100) ? 1100 : i);
      end
   endtask

   initial begin
      int bad;
      vt[0]  = '{24, 255,  24'h303030, 1'b0};
      vt[1]  = '{24, 256,  24'hF80000, 1'b1};
      vt[2]  = '{24, 257,  24'hF80000, 1'b1};
      vt[3]  = '{24, 258,  24'hF80000, 1'b1};
      vt[4]  = '{24, 271,  24'hF80000, 1'b1};
      vt[5]  = '{24, 640,  24'hF8F8F8, 1'b1};
      vt[6]  = '{24, 1023, 24'h00F800, 1'b1};
      vt[7]  = '{24, 1024, 24'h303030, 1'b0};
      vt[8]  = '{25, 256,  24'hF80000, 1'b1};
      vt[9]  = '{25, 640,  24'hF8F8F8, 1'b1};
      vt[10] = '{26, 256,  R26,        1'b1};
      vt[11] = '{26, 640,  W26,        1'b1};
      vt[12] = '{26, 1021, G26,        1'b1};
      vt[13] = '{26, 1024, 24'h303030, 1'b0};

      resetn          = 1'b1;
      bus.pix_we      = 1'b0;
      bus.pix_x       = '0;
      bus.pix_y       = '0;
      bus.pix_rgb     = '0;
      bus.line_done   = 1'b0;
      bus.frame_start = 1'b0;
      bus.disp_cx     = '0;
      bus.disp_cy     = '0;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rgb_out", 32'(bus.rgb_out), 32'h303030);
      chk("rst_rgb_active", 32'(bus.rgb_active), 0);
      chk("rst_pause", 32'(bus.pause_src), 0);
      chk("rst_underrun_cnt", 32'(bus.underrun_cnt), 0);
      chk("rst_sync_timeouts", 32'(bus.sync_timeouts), 0);
      resetn = 1'b1;

      // Line 0: red left half, white right half; y=224 must be dropped, y=16 wraps onto line 0.
      for (int x = 0; x < 256; x++) wr_pix(0, x, (x < 128) ? 15'h001F : 15'h7FFF);
      wr_pix(224, 5, 15'h7FFF);
      wr_pix(16, 255, 15'h03E0);
      @(negedge clk) bus.pix_we = 1'b0;

      // Sync with a parked raster: pause must expire after exactly TIMEOUT cycles.
      pulse_fs();
      pulse_ld();
      pulse_ld();
      chk("pause_before_sync", 32'(bus.pause_src), 0);
      @(negedge clk);
      chk("pause_rise", 32'(bus.pause_src), 1);
      repeat (99) @(negedge clk);
      chk("pause_held_99", 32'(bus.pause_src), 1);
      @(negedge clk);
      chk("pause_timeout_drop", 32'(bus.pause_src), 0);
      chk("sync_timeouts", 32'(bus.sync_timeouts), 1);
      chk("state_after_timeout", 32'(dut.state_q), 32'(RUN));

      @(negedge clk);
      bus.frame_start = 1'b1;
      bus.line_done   = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.line_done   = 1'b0;
      chk("fs_ld_coincide_wr", 32'(dut.wr_count_q), 0);

      // Second sync released by the raster reaching the first active pixel.
      next_row(24);
      pulse_ld();
      pulse_ld();
      chk("pause_before_sync2", 32'(bus.pause_src), 0);
      @(negedge clk);
      chk("pause_rise2", 32'(bus.pause_src), 1);

      for (int r = 24; r <= 26; r++) begin
         sweep_row(r, (r == 24) ? 250 : 0);
         if (r == 24) begin
            chk("pause_at_cx256", 32'(pz[256]), 1);
            chk("pause_fall", 32'(pz[257]), 0);
            chk("state_run", 32'(dut.state_q), 32'(RUN));
         end
         for (int k = 0; k < 14; k++) begin
            if (vt[k].cy == r) begin
               chk($sformatf("vec%0d_rgb", k), 32'(cap_rgb[vt[k].cx]), 32'(vt[k].rgb));
               chk($sformatf("vec%0d_act", k), 32'(cap_act[vt[k].cx]), 32'(vt[k].act));
            end
         end
      end

      // Underrun: sy=1 on row 27 while only one line is written.
      pulse_fs();
      pulse_ld();
      sweep_row(27, 0);
      bad = 0;
      for (int cx = 256; cx < 1024; cx++)
         if (cap_rgb[cx] !== 24'hFF00FF || cap_act[cx] !== 1'b1) bad++;
      chk("underrun_row_pixels_bad", 32'(bad), 0);
      chk("underrun_border", 32'(cap_rgb[1024]), 32'h303030);
      chk("underrun_cnt", 32'(bus.underrun_cnt), 1);

      // Throttle with 2 lines of hysteresis.
      pulse_fs();
      pulse_ld();
      pulse_ld();
      @(negedge clk);
      @(negedge clk) begin bus.disp_cy = 10'd24; bus.disp_cx = 11'd0; end
      @(negedge clk) bus.disp_cx = 11'd256;
      @(negedge clk) bus.disp_cx = 11'd1100;
      @(negedge clk);
      chk("thr_run_idle", 32'(bus.pause_src), 0);
      repeat (12) pulse_ld();
      repeat (2) @(negedge clk);
      chk("thr_gap14", 32'(bus.pause_src), 0);
      pulse_ld();
      repeat (2) @(negedge clk);
      chk("thr_gap15", 32'(bus.pause_src), 1);
      for (int cy = 25; cy <= 27; cy++) next_row(cy);
      repeat (2) @(negedge clk);
      chk("thr_hyst_gap14", 32'(bus.pause_src), 1);
      for (int cy = 28; cy <= 30; cy++) next_row(cy);
      repeat (2) @(negedge clk);
      chk("thr_clear_gap13", 32'(bus.pause_src), 0);

      repeat (230) pulse_ld();
      chk("wr_count_sat", 32'(dut.wr_count_q), 224);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/snes_linebuf_scaler.md
Name: snes_linebuf_scaler

Overview:
- Parametrised successor to the SNES-to-HDMI line-buffer path, in a single clock domain (the pixel clock).
- Captures SNES pixels into a multi-line BRAM ring. Replays them into a display raster with an integer scale factor, using counters rather than a divider.
- Adds underrun detection, an overrun throttle, and a frame-sync pause FSM with timeout that drives the SNES pause request.
- Sits between the PPU pixel-write interface (already synchronised) and the HDMI encoder's rgb input.

Parameters:
- SRC_W, 256, source pixels per line; power of 2, at most 256.
- SRC_H, 224, active source lines per frame.
- SCALE, 3, integer upscale factor, 1..7, applied to both x and y.
- LINE_BITS, 4, log2 of the number of buffered lines (16 lines).
- H_OFF, 256, display cx of the first active pixel.
- V_OFF, 24, display cy of the first active line.
- SYNC_LINES, 2, source lines written before the frame-sync pause.
- TIMEOUT, 2000000, maximum cycles the pause may be held.
- BORDER_RGB, 24'h303030, colour outside the active window.
- UNDERRUN_RGB, 24'hFF00FF, colour shown for a line not yet written.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- pix_we  in  1  write strobe for one source pixel.
- pix_x  in  8  source x.
- pix_y  in  8  source y.
- pix_rgb  in  15  BGR555 pixel.
- line_done  in  1  one-cycle pulse at the end of each written source line.
- frame_start  in  1  one-cycle pulse at the source vblank end.
- disp_cx  in  11  display column.
- disp_cy  in  10  display row.
- rgb_out  out  24  {R8,G8,B8}.
- rgb_active  out  1  rgb_out lies inside the active window.
- pause_src  out  1  request to halt the SNES.
- underrun_cnt  out  16  saturating count of display lines that underran.
- sync_timeouts  out  8  saturating count of pause timeouts.

Behaviour:
- Reset (asynchronous, resetn=0) sets:
  - rgb_out=BORDER_RGB, rgb_active=0, pause_src=0;
  - both counters to 0;
  - wr_count=0, FSM state IDLE;
  - x/y scale counters to 0.
- Reset does not clear RAM contents.
- Write side:
  - A pix_we with pix_y<SRC_H and pix_x<SRC_W writes RAM[{pix_y[LINE_BITS-1:0], pix_x}]. Other writes are dropped.
  - wr_count (9 bits) increments on line_done and saturates at SRC_H.
  - frame_start clears wr_count. If line_done and frame_start coincide, frame_start wins and wr_count becomes 0.
- Read side:
  - Active window: H_OFF <= cx < H_OFF+SRC_W*SCALE, and V_OFF <= cy < V_OFF+SRC_H*SCALE.
  - xsub/sx reset at cx==H_OFF. xsub counts 0..SCALE-1; sx increments on xsub wrap.
  - ysub/sy reset at cx==0 when cy==V_OFF. Both advance at cx==0 on each later row inside the window.
  - Read address is {sy[LINE_BITS-1:0], sx}; RAM read latency is 1 cycle.
  - rgb_out is registered: 2 cycles from disp_cx/disp_cy to rgb_out.
  - Expansion: R={d[4:0],3'b0}, G={d[9:5],3'b0}, B={d[14:10],3'b0}.
- Underrun:
  - Condition: active window and sy >= wr_count. While true, the output is UNDERRUN_RGB.
  - underrun_cnt increments at most once per display row and saturates at 16'hFFFF.
- FSM states IDLE, ARMED, HOLD, RUN:
  - IDLE -> ARMED on frame_start.
  - ARMED -> HOLD when wr_count==SYNC_LINES; pause_src=1.
  - HOLD -> RUN when cy==V_OFF and cx==H_OFF; pause_src=0.
  - HOLD -> RUN on a timeout after TIMEOUT cycles; sync_timeouts increments (saturating).
  - RUN -> ARMED on frame_start.
  - frame_start in HOLD -> ARMED with pause_src=0.
  - Throttle: in RUN, pause_src=1 while (wr_count - sy) >= 2^LINE_BITS-1. It clears once the gap is <= 2^LINE_BITS-3, which gives 2 lines of hysteresis.
- Boundaries:
  - sy never wraps within a frame.
  - RAM addressing wraps modulo 2^LINE_BITS lines.

Optional Feature:
- Macro: SNES_SCANLINE_EN.
- When defined: on display rows with ysub==SCALE-1, each active-pixel channel is shifted right by 1 (50% dim). This is applied after the underrun colour mux, and it is not applied to BORDER_RGB.
- When undefined: no dimming, and the ysub compare logic is not synthesised.
- Latency is unchanged in both cases.

Decomposition:
- Package snes_video_pkg:
  - typedef rgb555_t (15 bits) and rgb888_t (24 bits);
  - enum sync_state_e {IDLE, ARMED, HOLD, RUN};
  - function expand555(rgb555_t) returning rgb888_t;
  - localparams for 720p window defaults.
- Sub-module linebuf_ram: simple dual-port, one write and one registered read, single clock, depth 2^LINE_BITS*SRC_W, width 15, inferred BRAM.

Test Plan:
- Write line 0 with pix_rgb=15'h001F at all x, pulse line_done twice, SCALE=3. At cy=24, cx=256..258 -> rgb_out=24'hF80000 with 2-cycle latency; cx=255 -> 24'h303030 and rgb_active=0.
- frame_start, then line_done x2 -> pause_src rises 1 cycle after wr_count==2. It falls 1 cycle after cy=24, cx=256, and state reads RUN.
- HOLD with no display advance, TIMEOUT=100 -> pause_src drops after 100 cycles and sync_timeouts=1.
- Display reaches cy=27 (sy=1) with wr_count=1 -> rgb_out=24'hFF00FF for the entire row and underrun_cnt=1 (not 768).
- RUN state, writer 15 lines ahead of sy with LINE_BITS=4 -> pause_src=1. It clears once the gap is 13.
- With SNES_SCANLINE_EN, a white pixel on cy=26 (ysub=2) -> rgb_out=24'h7C7C7C; on cy=25 -> 24'hF8F8F8.
